main_act_ctrl: RTL and testbench

- Sequential source of the top-level ACT strobe that feeds the core's main activation fan-out, which distributes ACT to every ex/id/if/me/wb stage and to the pipeline and flush control.
- Holds the core inactive for a programmable post-reset window, then runs.
- Supports a debug halt/resume handshake that drains the superscalar pipeline before ACT drops.
- Counts active cycles.

---
 rtl/main_act_ctrl.sv | 142 ++++++++++++++
 tb/tb_main_act_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/main_act_ctrl.sv
// Top-level ACT source: post-reset hold-off, debug halt/drain/resume handshake, active-cycle count.
// Optional single-step from HALTED is enabled by defining MAIN_ACT_STEP_EN (adds step_req port).
module main_act_ctrl #(
    parameter int INIT_CYCLES   = 4,
    parameter int NUM_STAGES    = 10,
    parameter int DRAIN_TIMEOUT = 64,
    parameter int CNT_W         = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  halt_req,
    input  logic                  resume_req,
`ifdef MAIN_ACT_STEP_EN
    input  logic                  step_req,
`endif
    input  logic [NUM_STAGES-1:0] stage_busy,
    output logic                  ACT,
    output logic                  fetch_stop,
    output logic                  halted,
    output logic                  drain_timeout,
    output logic [CNT_W-1:0]      active_cycles
);

    localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int DW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam logic [IW-1:0] INIT_LAST  = (INIT_CYCLES > 0) ? IW'(INIT_CYCLES - 1) : '0;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_RUN    = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_HALTED = 3'd3
`ifdef MAIN_ACT_STEP_EN
        ,ST_STEP  = 3'd4
`endif
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   init_cnt;
    logic [DW-1:0]   drain_cnt;
    logic            timeout_hit;
    logic            act_nxt;
    logic            fetch_stop_nxt;
    logic            halted_nxt;
    logic            drain_timeout_nxt;

    // Outputs are registered from the next-state decode so they change on the same edge as state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= ST_INIT;
            init_cnt      <= '0;
            drain_cnt     <= '0;
            ACT           <= 1'b0;
            fetch_stop    <= 1'b0;
            halted        <= 1'b0;
            drain_timeout <= 1'b0;
            active_cycles <= '0;
        end else begin
            state         <= state_nxt;
            ACT           <= act_nxt;
            fetch_stop    <= fetch_stop_nxt;
            halted        <= halted_nxt;
            drain_timeout <= drain_timeout_nxt;
            if (state == ST_INIT)
                init_cnt <= init_cnt + IW'(1);
            if (state == ST_RUN)
                drain_cnt <= '0;
            else if (state == ST_DRAIN)
                drain_cnt <= drain_cnt + DW'(1);
            if (ACT)
                active_cycles <= active_cycles + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt   = state;
        timeout_hit = 1'b0;
        case (state)
            ST_INIT: begin
                if (INIT_CYCLES == 0 || init_cnt == INIT_LAST)
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (halt_req)
                    state_nxt = ST_DRAIN;
            end
            // Abort beats both the idle exit and the forced exit.
            ST_DRAIN: begin
                if (resume_req)
                    state_nxt = ST_RUN;
                else if (~|stage_busy)
                    state_nxt = ST_HALTED;
                else if (drain_cnt == DRAIN_LAST) begin
                    state_nxt   = ST_HALTED;
                    timeout_hit = 1'b1;
                end
            end
            ST_HALTED: begin
                if (resume_req)
                    state_nxt = ST_RUN;
`ifdef MAIN_ACT_STEP_EN
                else if (step_req)
                    state_nxt = ST_STEP;
`endif
            end
`ifdef MAIN_ACT_STEP_EN
            ST_STEP:   state_nxt = ST_HALTED;
`endif
            default:   state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        act_nxt        = 1'b0;
        fetch_stop_nxt = 1'b0;
        halted_nxt     = 1'b0;
        case (state_nxt)
            ST_RUN:    act_nxt = 1'b1;
            ST_DRAIN: begin
                act_nxt        = 1'b1;
                fetch_stop_nxt = 1'b1;
            end
            ST_HALTED: begin
                fetch_stop_nxt = 1'b1;
                halted_nxt     = 1'b1;
            end
`ifdef MAIN_ACT_STEP_EN
            ST_STEP:   act_nxt = 1'b1;
`endif
            default: ;
        endcase

        drain_timeout_nxt = drain_timeout;
        if (state == ST_RUN && state_nxt == ST_DRAIN)
            drain_timeout_nxt = 1'b0;
        else if (timeout_hit)
            drain_timeout_nxt = 1'b1;
    end

endmodule

// File: tb/tb_main_act_ctrl.sv
// Bench for main_act_ctrl: directed scenarios then random traffic, every cycle compared to a reference model.
module tb_main_act_ctrl;

    localparam int INIT_CYCLES = 4;
    localparam int NUM_STAGES  = 10;
    localparam int DRAIN_TO    = 64;
    localparam int CW          = 4;
`ifdef MAIN_ACT_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    localparam int M_INIT = 0, M_RUN = 1, M_DRAIN = 2, M_HALT = 3, M_STEP = 4;

    logic                  CLK = 1'b0;
    logic                  RST = 1'b1;
    logic                  halt_req = 1'b0;
    logic                  resume_req = 1'b0;
`ifdef MAIN_ACT_STEP_EN
    logic                  step_req = 1'b0;
`endif
    logic [NUM_STAGES-1:0] stage_busy = '0;
    logic                  ACT;
    logic                  fetch_stop;
    logic                  halted;
    logic                  drain_timeout;
    logic [CW-1:0]         active_cycles;

    int compared = 0;
    int mismatched = 0;

    int mode, init_left, age, m_cnt;
    bit m_act, m_fs, m_hlt, m_dto;

    main_act_ctrl #(
        .INIT_CYCLES  (INIT_CYCLES),
        .NUM_STAGES   (NUM_STAGES),
        .DRAIN_TIMEOUT(DRAIN_TO),
        .CNT_W        (CW)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .halt_req     (halt_req),
        .resume_req   (resume_req),
`ifdef MAIN_ACT_STEP_EN
        .step_req     (step_req),
`endif
        .stage_busy   (stage_busy),
        .ACT          (ACT),
        .fetch_stop   (fetch_stop),
        .halted       (halted),
        .drain_timeout(drain_timeout),
        .active_cycles(active_cycles)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: one call per clock edge, applying the rules to the sampled inputs.
    task automatic model(input bit r, input bit h, input bit res, input bit s, input logic [NUM_STAGES-1:0] b);
        if (r) begin
            mode = M_INIT; init_left = INIT_CYCLES; age = 0; m_dto = 0; m_cnt = 0;
        end else begin
            if (m_act) m_cnt = (m_cnt + 1) % (1 << CW);
            case (mode)
                M_INIT:  if (init_left <= 1) mode = M_RUN; else init_left--;
                M_RUN:   if (h) begin mode = M_DRAIN; age = 0; m_dto = 0; end
                M_DRAIN: begin
                    if (res) mode = M_RUN;
                    else if (b == 0) mode = M_HALT;
                    else if (age == DRAIN_TO - 1) begin mode = M_HALT; m_dto = 1; end
                    else age++;
                end
                M_HALT:  if (res) mode = M_RUN; else if (s && STEP_EN) mode = M_STEP;
                default: mode = M_HALT;
            endcase
        end
        m_act = (mode == M_RUN) || (mode == M_DRAIN) || (mode == M_STEP);
        m_fs  = (mode == M_DRAIN) || (mode == M_HALT);
        m_hlt = (mode == M_HALT);
    endtask

    task automatic tick(input bit r, input bit h, input bit res, input bit s, input logic [NUM_STAGES-1:0] b);
        RST = r; halt_req = h; resume_req = res; stage_busy = b;
`ifdef MAIN_ACT_STEP_EN
        step_req = s;
`endif
        @(posedge CLK);
        model(r, h, res, s, b);
        #1;
        chk("act", 32'(ACT), 32'(m_act));
        chk("fetch_stop", 32'(fetch_stop), 32'(m_fs));
        chk("halted", 32'(halted), 32'(m_hlt));
        chk("drain_timeout", 32'(drain_timeout), 32'(m_dto));
        chk("active_cycles", 32'(active_cycles), 32'(m_cnt));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_act"}, 32'(ACT), 0);
        chk({tag, "_fs"}, 32'(fetch_stop), 0);
        chk({tag, "_halted"}, 32'(halted), 0);
        chk({tag, "_dto"}, 32'(drain_timeout), 0);
        chk({tag, "_cnt"}, 32'(active_cycles), 0);
    endtask

    initial begin
        logic [NUM_STAGES-1:0] b;
        mode = M_INIT; init_left = INIT_CYCLES; age = 0; m_cnt = 0;
        m_act = 0; m_fs = 0; m_hlt = 0; m_dto = 0;

        tick(1, 0, 0, 0, '0);
        tick(1, 0, 0, 0, '0);
        chk_reset_vals("reset");

        // Hold-off window; requests during it are ignored.
        tick(0, 1, 0, 0, '0);
        chk("init_act_low1", 32'(ACT), 0);
        tick(0, 0, 1, 0, '0);
        tick(0, 1, 1, 0, '0);
        chk("init_act_low3", 32'(ACT), 0);
        tick(0, 0, 0, 0, '0);
        chk("init_act_high", 32'(ACT), 1);
        tick(0, 0, 0, 0, '0);
        chk("first_count", 32'(active_cycles), 1);
        tick(0, 0, 0, 0, '0);

        // Drain that completes once busy clears.
        tick(0, 1, 0, 0, 10'h3);
        chk("drain_fs", 32'(fetch_stop), 1);
        tick(0, 0, 0, 0, 10'h3);
        tick(0, 0, 0, 0, 10'h3);
        chk("drain_not_halted", 32'(halted), 0);
        tick(0, 0, 0, 0, '0);
        chk("idle_halted", 32'(halted), 1);
        chk("idle_act", 32'(ACT), 0);
        chk("idle_dto", 32'(drain_timeout), 0);
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 0, '0);
        tick(0, 0, 1, 0, '0);
        chk("resume_act", 32'(ACT), 1);
        for (int i = 0; i < 20; i++) tick(0, 0, 0, 0, '0);

        // Forced halt after the drain limit.
        tick(0, 1, 0, 0, 10'h1);
        for (int i = 1; i < DRAIN_TO; i++) tick(0, 0, 0, 0, 10'h1);
        chk("to_edge63_halted", 32'(halted), 0);
        tick(0, 0, 0, 0, 10'h1);
        chk("to_halted", 32'(halted), 1);
        chk("to_dto", 32'(drain_timeout), 1);
        tick(0, 0, 1, 0, 10'h1);
        chk("to_resume_act", 32'(ACT), 1);
        chk("to_dto_sticky", 32'(drain_timeout), 1);

        // Simultaneous requests.
        tick(0, 1, 1, 0, 10'h1);
        chk("both_run_fs", 32'(fetch_stop), 1);
        chk("both_run_dto_clr", 32'(drain_timeout), 0);
        tick(0, 1, 1, 0, 10'h1);
        chk("both_drain_fs", 32'(fetch_stop), 0);
        chk("both_drain_act", 32'(ACT), 1);

        // Reset in the middle of a drain.
        tick(0, 1, 0, 0, 10'h1);
        tick(0, 0, 0, 0, 10'h1);
        tick(1, 0, 0, 0, 10'h1);
        chk_reset_vals("mid_drain_rst");
        for (int i = 0; i < INIT_CYCLES + 2; i++) tick(0, 0, 0, 0, '0);

`ifdef MAIN_ACT_STEP_EN
        tick(0, 1, 0, 0, '0);
        tick(0, 0, 0, 0, '0);
        tick(0, 0, 0, 1, '0);
        chk("step_act", 32'(ACT), 1);
        chk("step_halted", 32'(halted), 0);
        chk("step_fs", 32'(fetch_stop), 0);
        tick(0, 0, 0, 0, '0);
        chk("step_back_halted", 32'(halted), 1);
        for (int i = 0; i < 5; i++) tick(0, 0, 0, 1, '0);
        tick(0, 0, 1, 1, '0);
`endif

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) b = '0;
            else if ($urandom_range(0, 1) == 0) b = 10'h1;
            else b = NUM_STAGES'($urandom);
            tick($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, b);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
